// File: rtl/serial_rx_uart.sv
// serial_rx_uart
//   UART receiver for 8N1 frames (8E1 when UART_RX_PARITY_EN is defined),
//   LSB first. The line is double-flop synchronised. The start bit is checked
//   at its midpoint. Every following bit is sampled one bit period later, so
//   sampling stays centred in each bit.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     Adds an even-parity bit between the data bits and the stop bit.
//     When the macro is undefined, parity_err is tied low.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   rx_in      in   serial line, idle high, asynchronous to clk
//   rx_data    out  last good byte, held until the next good byte
//   rx_valid   out  1-cycle pulse: new byte on rx_data
//   rx_busy    out  high while the receiver is not idle
//   frame_err  out  1-cycle pulse: stop bit sampled low
//   parity_err out  1-cycle pulse: parity mismatch on an otherwise good frame
module serial_rx_uart #(
  parameter int BPS      = 5624,  // clocks per bit minus 1
  parameter int HALF_BPS = 2812   // clocks to mid start bit minus 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_sync1;
  logic        r_rx_s;
  logic        r_rx_p;
  logic [15:0] r_bit_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_frame_err;
  logic        w_sample;
  logic        w_bit_end;
  logic        w_parity_ok;

  assign w_bit_end = (r_bit_cnt == 16'(BPS));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      // Falling edge on the synchronised line starts a frame.
      S_IDLE:      if (r_rx_p && !r_rx_s) w_next_state = S_START;
      // A high midpoint means the low was a glitch, not a start bit.
      S_START:     if (r_bit_cnt == 16'(HALF_BPS))
                     w_next_state = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:      if (w_bit_end && r_bit_idx == 3'd7) w_next_state = S_PARITY;
      S_PARITY:    if (w_bit_end) w_next_state = S_STOP;
`else
      S_DATA:      if (w_bit_end && r_bit_idx == 3'd7) w_next_state = S_STOP;
`endif
      S_STOP:      if (w_bit_end) w_next_state = r_rx_s ? S_IDLE : S_WAIT_HIGH;
      // A break (line held low) must not be read as a new start bit.
      S_WAIT_HIGH: if (r_rx_s) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    rx_busy  = (r_state != S_IDLE);
    w_sample = 1'b0;
    case (r_state)
      S_START:                  w_sample = (r_bit_cnt == 16'(HALF_BPS));
      S_DATA, S_PARITY, S_STOP: w_sample = w_bit_end;
      default:                  w_sample = 1'b0;
    endcase
  end

  // Two-flop synchroniser plus one delay stage for edge detection. The flops
  // reset to 1, so a line that is low at release reads as a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_p  <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_rx_s  <= r_sync1;
      r_rx_p  <= r_rx_s;
    end
  end

  // Bit timing: the counter restarts on every state change and every sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_next_state != r_state || w_sample) r_bit_cnt <= '0;
      else                                     r_bit_cnt <= r_bit_cnt + 16'd1;
      if (r_state == S_START) r_bit_idx <= '0;
      if (r_state == S_DATA && w_sample) begin
        r_shift[r_bit_idx] <= r_rx_s;
        r_bit_idx          <= r_bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_parity_bit;
  logic r_parity_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_parity_bit <= 1'b0;
    else if (r_state == S_PARITY && w_sample) r_parity_bit <= r_rx_s;
  end

  // Even parity: data bits plus the parity bit must XOR to 0.
  assign w_parity_ok = ~^{r_shift, r_parity_bit};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_parity_err <= 1'b0;
    else r_parity_err <= (r_state == S_STOP) && w_sample && r_rx_s && !w_parity_ok;
  end
  assign parity_err = r_parity_err;
`else
  assign w_parity_ok = 1'b1;
  assign parity_err  = 1'b0;
`endif

  // Result strobes. A bad stop bit takes priority over a parity error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state == S_STOP && w_sample) begin
        if (!r_rx_s) begin
          r_frame_err <= 1'b1;
        end else if (w_parity_ok) begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= r_shift;
        end
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_rx_uart.sv
`timescale 1ps/1ps
module tb_serial_rx_uart;

  localparam int CLK_PS = 10000;
  localparam int BIT_PS = 16 * CLK_PS;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  // Drive edge -> rx_valid register edge:
  // 3 sync/edge clocks + 8 to mid start bit + 16 per data/parity/stop bit.
  localparam int LAT = 3 + 8 + (NBITS + 1) * 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, parity_err;

  serial_rx_uart #(.BPS(15), .HALF_BPS(7)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err),
    .parity_err(parity_err)
  );

  always #(CLK_PS/2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       kind;   // 0 valid, 1 frame_err, 2 parity_err
    logic [7:0] data; // rx_data expected while the pulse is high
    int       t0;
    bit       chk_lat;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Monitor: pops one expectation per pulse.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      int n;
      int k;
      n = int'(rx_valid) + int'(frame_err) + int'(parity_err);
      k = rx_valid ? 0 : (frame_err ? 1 : 2);
      if (n > 1) check("pulse_exclusive", n, 1);
      if (n >= 1) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got kind %0d rx_data %0h, required none", k, rx_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pulse_kind", k, e.kind);
          check("rx_data", rx_data, e.data);
          if (e.chk_lat) check("latency", cyc - e.t0, LAT);
          $display("frame: kind=%0d rx_data=%02h (expected kind=%0d data=%02h)", k, rx_data, e.kind, e.data);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                      input int bit_ps, input bit chk);
    exp_t e;
    e.t0 = cyc;
    e.chk_lat = chk;
    if (!stop_bit) begin
      e.kind = 1; e.data = last_good;
    end else if (par_flip) begin
      e.kind = 2; e.data = last_good;
    end else begin
      e.kind = 0; e.data = b; last_good = b;
    end
    q.push_back(e);
    rx_in = 1'b0;
    #(bit_ps);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      #(bit_ps);
    end
`ifdef UART_RX_PARITY_EN
    rx_in = (^b) ^ par_flip;
    #(bit_ps);
`endif
    rx_in = stop_bit;
    #(bit_ps);
  endtask

  task automatic align();
    @(posedge clk);
    #1000;
  endtask

  initial begin
    int waited;
    int skew;
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1000;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_pulses", {rx_valid, frame_err, parity_err}, 3'b000);
    check("reset_busy", rx_busy, 1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (20) @(posedge clk);
    #1000 check("idle_after_reset_busy", rx_busy, 1'b0);

    // Back-to-back frames, no idle gap.
    align();
    send(8'h55, 1'b1, 1'b0, BIT_PS, 1'b1);
    send(8'hA3, 1'b1, 1'b0, BIT_PS, 1'b1);
    repeat (10) @(posedge clk);

    // Asynchronous reset in the middle of a frame.
    align();
    rx_in = 1'b0;
    repeat (50) @(posedge clk);
    #3000 reset = 1'b0;
    #1000;
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_busy", rx_busy, 1'b0);
    check("midreset_pulses", {rx_valid, frame_err, parity_err}, 3'b000);
    last_good = 8'h00;
    rx_in = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (200) @(posedge clk);
    #1000 check("after_midreset_busy", rx_busy, 1'b0);

    // 3-clock glitch on an idle line.
    align();
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1000 rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1000 check("glitch_busy_in_start", rx_busy, 1'b1);
    repeat (9) @(posedge clk);
    #1000 check("glitch_back_idle", rx_busy, 1'b0);
    repeat (30) @(posedge clk);

    // Good byte, then a bad stop bit followed by a 40-clock break.
    align();
    send(8'h81, 1'b1, 1'b0, BIT_PS, 1'b1);
    send(8'h3C, 1'b0, 1'b0, BIT_PS, 1'b1);
    repeat (24) @(posedge clk);
    #1000 check("break_wait_high_busy", rx_busy, 1'b1);
    rx_in = 1'b1;
    repeat (4) @(posedge clk);
    #1000 check("break_released_idle", rx_busy, 1'b0);
    align();
    send(8'h7E, 1'b1, 1'b0, BIT_PS, 1'b1);
    repeat (10) @(posedge clk);

`ifdef UART_RX_PARITY_EN
    align();
    send(8'h07, 1'b1, 1'b0, BIT_PS, 1'b1);
    send(8'h07, 1'b1, 1'b1, BIT_PS, 1'b1);
    repeat (10) @(posedge clk);
`endif

    // 200 random bytes with +/-2% baud skew.
    for (int i = 0; i < 200; i++) begin
      skew = int'($urandom_range(0, 4)) - 2;
      send(8'($urandom_range(0, 255)), 1'b1, 1'b0, BIT_PS + skew * (BIT_PS / 100), 1'b0);
    end
    rx_in = 1'b1;

    waited = 0;
    while (q.size() != 0 && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    check("all_expected_seen", q.size(), 0);
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
